// File: rtl/td4_program_store.sv
// TD4 program store: 16x8 program memory loaded from pins, fetched by CPU pc.
// Optional single-step execution gated by macro TD4_SINGLE_STEP_EN.
module td4_program_store #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        data_in,
    input  logic              wr_strobe,
    input  logic              addr_clr,
    input  logic              run,
    input  logic              step,
    input  logic [ADDR_W-1:0] pc,
    output logic [3:0]        opcode,
    output logic [3:0]        immediate,
    output logic              exec_mode,
    output logic [ADDR_W-1:0] load_addr,
    output logic              prog_full
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic ST_LOAD = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic [7:0]             mem [DEPTH];
    logic                   state;
    logic                   state_next;
    logic                   exec_next;

    logic [SYNC_STAGES-1:0] wr_sync_q;
    logic [SYNC_STAGES-1:0] run_sync_q;
    logic                   wr_dly;
    logic                   wr_sync;
    logic                   run_sync;
    logic                   wr_pulse;
    logic                   step_gate;

    assign wr_sync  = wr_sync_q[SYNC_STAGES-1];
    assign run_sync = run_sync_q[SYNC_STAGES-1];
    assign wr_pulse = wr_sync & ~wr_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync_q  <= '0;
            run_sync_q <= '0;
            wr_dly     <= 1'b0;
        end else begin
            wr_sync_q  <= {wr_sync_q[SYNC_STAGES-2:0], wr_strobe};
            run_sync_q <= {run_sync_q[SYNC_STAGES-2:0], run};
            wr_dly     <= wr_sync;
        end
    end

`ifdef TD4_SINGLE_STEP_EN
    logic [SYNC_STAGES-1:0] step_sync_q;
    logic                   step_dly;
    logic                   step_sync;

    assign step_sync = step_sync_q[SYNC_STAGES-1];
    assign step_gate = step_sync & ~step_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_sync_q <= '0;
            step_dly    <= 1'b0;
        end else begin
            step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], step};
            step_dly    <= step_sync;
        end
    end
`else
    logic unused_step;
    assign unused_step = step;
    assign step_gate   = 1'b1;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: if (run_sync)  state_next = ST_RUN;
            ST_RUN:  if (!run_sync) state_next = ST_LOAD;
            default: state_next = ST_LOAD;
        endcase
        exec_next = (state_next == ST_RUN) && step_gate;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_LOAD;
            exec_mode <= 1'b0;
        end else begin
            state     <= state_next;
            exec_mode <= exec_next;
        end
    end

    // addr_clr has priority over a coincident strobe edge, dropping that write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            load_addr <= '0;
            prog_full <= 1'b0;
        end else if (addr_clr) begin
            load_addr <= '0;
            prog_full <= 1'b0;
        end else if (wr_pulse && state == ST_LOAD) begin
            mem[load_addr] <= data_in;
            load_addr      <= load_addr + 1'b1;
            if (load_addr == '1) prog_full <= 1'b1;
        end
    end

    assign {opcode, immediate} = mem[pc];

endmodule

// File: tb/tb_td4_program_store.sv
// Directed, table-driven bench for td4_program_store (SYNC_STAGES = 2).
module tb_td4_program_store;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       wr_strobe;
    logic       addr_clr;
    logic       run;
    logic       step;
    logic [3:0] pc;
    logic [3:0] opcode;
    logic [3:0] immediate;
    logic       exec_mode;
    logic [3:0] load_addr;
    logic       prog_full;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        logic [3:0] exp_addr;
        logic       exp_full;
    } vec_t;

    vec_t vec [16];

    td4_program_store #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .wr_strobe (wr_strobe),
        .addr_clr  (addr_clr),
        .run       (run),
        .step      (step),
        .pc        (pc),
        .opcode    (opcode),
        .immediate (immediate),
        .exec_mode (exec_mode),
        .load_addr (load_addr),
        .prog_full (prog_full)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_mem(input string name, input logic [3:0] a, input logic [7:0] exp);
        pc = a;
        #1;
        chk(name, {opcode, immediate}, exp);
    endtask

    // Strobe pulse lands at the 3rd edge after rising; low phase lets edge flops settle.
    task automatic strobe(input logic [7:0] d);
        data_in   = d;
        wr_strobe = 1'b1;
        tick(3);
        wr_strobe = 1'b0;
        tick(3);
    endtask

    initial begin
        int pulses;
        vec[0] = '{8'hC5, 4'd1, 1'b0};
        vec[1] = '{8'h0A, 4'd2, 1'b0};
        for (int i = 2; i < 16; i++) begin
            vec[i].data     = {4'(i), ~4'(i)};
            vec[i].exp_addr = 4'(i + 1);
            vec[i].exp_full = (i == 15);
        end

        rst_n = 1'b0; data_in = '0; wr_strobe = 0; addr_clr = 0;
        run = 0; step = 0; pc = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);

        chk("reset_load_addr", load_addr, 0);
        chk("reset_prog_full", prog_full, 0);
        chk("reset_exec_mode", exec_mode, 0);
        for (int i = 0; i < 16; i++) chk_mem("reset_mem", 4'(i), 8'h00);

        // First write: verify it lands exactly SYNC_STAGES+1 edges after the pin edge.
        pc = 4'd0;
        data_in = vec[0].data;
        wr_strobe = 1'b1;
        tick(2);
        chk("latency_before", {opcode, immediate}, 8'h00);
        tick(1);
        chk("latency_after", {opcode, immediate}, 8'hC5);
        wr_strobe = 1'b0;
        tick(3);
        chk("first_addr", load_addr, 1);

        for (int i = 1; i < 16; i++) begin
            strobe(vec[i].data);
            chk("table_addr", load_addr, vec[i].exp_addr);
            chk("table_full", prog_full, vec[i].exp_full);
            chk_mem("table_mem", 4'(i), vec[i].data);
        end
        chk_mem("pc0_after_load", 4'd0, 8'hC5);

        strobe(8'hFF);
        chk_mem("wrap_mem0", 4'd0, 8'hFF);
        chk("wrap_full_sticky", prog_full, 1);
        chk("wrap_addr", load_addr, 1);

        addr_clr = 1'b1; tick(1); addr_clr = 1'b0;
        chk("clr_full", prog_full, 0);
        chk("clr_addr", load_addr, 0);

        for (int i = 0; i < 5; i++) strobe(8'h90 | 8'(i));
        chk("pre_collision_addr", load_addr, 5);

        data_in = 8'h33;
        wr_strobe = 1'b1;
        tick(2);
        addr_clr = 1'b1;
        tick(1);
        addr_clr = 1'b0;
        wr_strobe = 1'b0;
        tick(3);
        chk_mem("collision_mem5", 4'd5, 8'h5A);
        chk("collision_addr", load_addr, 0);

        pc = 4'd0;
        run = 1'b1;
        tick(2);
        chk("run_latency_before", exec_mode, 0);
        tick(1);
`ifdef TD4_SINGLE_STEP_EN
        chk("run_step_idle", exec_mode, 0);
`else
        chk("run_latency_after", exec_mode, 1);
`endif
        strobe(8'h77);
        chk("run_no_addr", load_addr, 0);
        chk_mem("run_no_write", 4'd0, 8'h90);

`ifdef TD4_SINGLE_STEP_EN
        pulses = 0;
        step = 1'b1;
        for (int k = 0; k < 10; k++) begin tick(1); pulses += int'(exec_mode); end
        step = 1'b0;
        for (int k = 0; k < 4; k++) begin tick(1); pulses += int'(exec_mode); end
        chk("step_hold_one_pulse", pulses, 1);
        pulses = 0;
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            for (int k = 0; k < 4; k++) begin tick(1); pulses += int'(exec_mode); end
            step = 1'b0;
            for (int k = 0; k < 4; k++) begin tick(1); pulses += int'(exec_mode); end
        end
        chk("step_three_pulses", pulses, 3);
`else
        pulses = 0;
        for (int k = 0; k < 10; k++) begin tick(1); pulses += int'(exec_mode); end
        chk("run_exec_constant", pulses, 10);
`endif

        run = 1'b0;
        tick(3);
        chk("load_exec_off", exec_mode, 0);

`ifdef TD4_SINGLE_STEP_EN
        pulses = 0;
        step = 1'b1;
        for (int k = 0; k < 6; k++) begin tick(1); pulses += int'(exec_mode); end
        step = 1'b0;
        tick(3);
        chk("load_step_ignored", pulses, 0);
`endif

        run = 1'b1;
        tick(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_exec", exec_mode, 0);
        chk("async_rst_mem", {opcode, immediate}, 8'h00);
        chk("async_rst_addr", load_addr, 0);
        run = 1'b0;
        tick(1);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
